seg7_scan_capture: RTL and testbench
====================================

// Module: seg7_scan_capture
// PURPOSE
//  Receive end of the multiplexed 7-segment display interface: samples the shared segment bus and
//  per-digit anode strobes driven by a scanning display driver, debounces each dwell, maps each
//  segment pattern back to a hex nibble and holds one registered value per digit.
//  Used as a self-check monitor on the board display pins and as loopback receiver in system benches.
// PARAMETERS
//  N_DIGITS        4   number of multiplexed digits (1..8)
//  STABLE_CYCLES   4   consecutive identical synced samples required before commit (>=2)
//  SEG_ACTIVE_LOW  1   1: segment lit when pin low; 0: lit when high
//  AN_ACTIVE_LOW   1   1: digit selected when anode pin low; 0: when high
// PORTS
//  clk         in   1           system clock, 50 MHz
//  rst         in   1           synchronous reset, active-high
//  seg_i       in   7           segment pins, bit0=a .. bit6=g (async to clk)
//  an_i        in   N_DIGITS    anode strobes, bit i = digit i (async to clk)
//  digits_o    out  4*N_DIGITS  decoded nibbles, digit i at [4*i+3:4*i]
//  valid_o     out  N_DIGITS    digit i holds a committed legal hex pattern
//  blank_o     out  N_DIGITS    last commit of digit i was all segments off
//  err_o       out  N_DIGITS    last commit of digit i was a non-hex, non-blank pattern
//  frame_o     out  1           1-cycle pulse: every digit committed at least once since last pulse/reset
//  conflict_o  out  1           1-cycle pulse: stable dwell with >1 anode active
// BEHAVIOUR
//  - Reset: digits_o=0, valid_o=0, blank_o=0, err_o=0, frame_o=0, conflict_o=0, counters/flags cleared.
//  - seg_i/an_i pass a 2-FF synchroniser, then are normalised to active-high per polarity params.
//  - Stability: cnt clears when synced {an,seg} differs from previous sample, else increments, saturating.
//    Commit fires once per dwell, on the edge where the same value has been seen STABLE_CYCLES times;
//    pin-to-output latency = STABLE_CYCLES+2 edges. No re-commit until {an,seg} changes.
//  - Commit, exactly one anode i active: legal pattern -> digits_o[i]=nibble, valid=1, blank=0, err=0;
//    pattern 0x00 -> blank=1, valid=0, err=0, nibble held; other -> err=1, valid=0, blank=0, nibble held.
//  - Commit, zero anodes: ignored (inter-digit blanking). >1 anode: no digit update, conflict_o pulses.
//  - Hex table (active-high gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
//    A=77 b=7C C=39 d=5E E=79 F=71.
//  - Frame: per-digit seen bit set on any single-anode commit; when all set, frame_o pulses the cycle
//    after the completing commit and all seen bits clear that same cycle (a commit on that edge is
//    recorded for the next frame).
//  - Dwell shorter than STABLE_CYCLES: no commit, outputs unchanged.
//  - rst mid-dwell: all state cleared; the dwell restarts counting from the first post-reset sample.
// STRUCTURE
//  - seg7_pkg: SEG_0..SEG_F and SEG_BLANK pattern constants, function seg2hex(pattern)->{legal,nibble}.
//  - Sub-module seg7_pat2hex: combinational 7-bit pattern -> {legal, blank, nibble} using seg7_pkg.
//  - Top: synchroniser, polarity normalise, stability counter, one-hot check, per-digit register file,
//    frame tracker.
// TESTING (defaults, active-low pins; clk period 20 ns; check #2 ns after posedge)
//  1 Reset 3 cycles, idle pins (an=F, seg=7F) -> all outputs 0, no frame_o/conflict_o for 20 cycles.
//  2 an=E (digit0), seg=~06 held 6 cycles -> digits_o[3:0]=1, valid_o=0001 exactly at edge 6, not 5.
//  3 Scan digits 0..3 with 3,A,d,F, 8-cycle dwells, 2-cycle an=F gaps -> digits_o=16'hFdA3,
//    valid_o=F, one frame_o pulse after digit3 commit.
//  4 Digit1 seg=~00 then seg=~49 -> blank_o[1]=1 then err_o[1]=1, valid_o[1]=0, nibble held.
//  5 an=C (two anodes) held 8 cycles -> conflict_o pulses once, digits_o/valid_o unchanged.
//  6 Glitch: 3-cycle dwell of new value -> no change; rst asserted mid-dwell -> outputs zero, recovery.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan receiver.
// Active-high gfedcba segment patterns for hex digits 0..F and the blank pattern,
// plus seg2hex(), which maps a pattern to {legal, nibble} (legal=0 for anything not in the table).
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_A     = 7'h77;
   localparam logic [6:0] SEG_B     = 7'h7C;
   localparam logic [6:0] SEG_C     = 7'h39;
   localparam logic [6:0] SEG_D     = 7'h5E;
   localparam logic [6:0] SEG_E     = 7'h79;
   localparam logic [6:0] SEG_F     = 7'h71;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Returns {legal, nibble}; nibble is 0 when the pattern is not a hex glyph.
   function automatic logic [4:0] seg2hex(input logic [6:0] pat);
      logic [4:0] r;
      r = 5'h00;
      case (pat)
         SEG_0:   r = 5'h10;
         SEG_1:   r = 5'h11;
         SEG_2:   r = 5'h12;
         SEG_3:   r = 5'h13;
         SEG_4:   r = 5'h14;
         SEG_5:   r = 5'h15;
         SEG_6:   r = 5'h16;
         SEG_7:   r = 5'h17;
         SEG_8:   r = 5'h18;
         SEG_9:   r = 5'h19;
         SEG_A:   r = 5'h1A;
         SEG_B:   r = 5'h1B;
         SEG_C:   r = 5'h1C;
         SEG_D:   r = 5'h1D;
         SEG_E:   r = 5'h1E;
         SEG_F:   r = 5'h1F;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seg7_pat2hex.sv
// Combinational segment-pattern decoder (active-high gfedcba in, hex nibble out).
// Ports: i_pat pattern; o_legal pattern is a hex glyph; o_blank all segments off;
//        o_nibble decoded value (0 when not legal).
module seg7_pat2hex
   import seg7_pkg::*;
(
   input  logic [6:0] i_pat,
   output logic       o_legal,
   output logic       o_blank,
   output logic [3:0] o_nibble
);

   logic [4:0] w_dec;

   assign w_dec    = seg2hex(i_pat);
   assign o_legal  = w_dec[4];
   assign o_nibble = w_dec[3:0];
   assign o_blank  = (i_pat == SEG_BLANK);

endmodule

// File: rtl/seg7_scan_capture.sv
// Receive side of a multiplexed 7-segment display: synchronises segment/anode pins, waits for a
// dwell to be stable for STABLE_CYCLES samples, then commits the decoded nibble to that digit.
// Ports: clk/rst (sync, active-high); seg_i/an_i raw pins; digits_o/valid_o/blank_o/err_o per-digit
//        state; frame_o pulse once every digit has committed; conflict_o pulse on multi-anode dwell.
module seg7_scan_capture
   import seg7_pkg::*;
#(
   parameter int N_DIGITS       = 4,
   parameter int STABLE_CYCLES  = 4,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            seg_i,
   input  logic [N_DIGITS-1:0]   an_i,
   output logic [4*N_DIGITS-1:0] digits_o,
   output logic [N_DIGITS-1:0]   valid_o,
   output logic [N_DIGITS-1:0]   blank_o,
   output logic [N_DIGITS-1:0]   err_o,
   output logic                  frame_o,
   output logic                  conflict_o
);

   localparam int CW = $clog2(STABLE_CYCLES);
   localparam int SW = N_DIGITS + 7;

   // Pin levels meaning "nothing lit, no digit selected"; synchronisers reset to these so a
   // reset never looks like a burst of all-anodes-active samples.
   localparam logic [6:0]          SEG_IDLE = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [N_DIGITS-1:0] AN_IDLE  = AN_ACTIVE_LOW ? {N_DIGITS{1'b1}} : '0;

   logic [6:0]          r_seg_s1, r_seg_s2;
   logic [N_DIGITS-1:0] r_an_s1, r_an_s2;

   logic [6:0]          w_seg;
   logic [N_DIGITS-1:0] w_an;
   logic [SW-1:0]       w_samp;
   logic [SW-1:0]       r_prev;
   logic [CW-1:0]       r_cnt;
   logic                w_same;
   logic                w_commit;
   logic                w_onehot;
   logic                w_multi;
   logic                w_legal, w_blank;
   logic [3:0]          w_nibble;
   logic                w_all_seen;

   logic [N_DIGITS-1:0][3:0] r_digits;
   logic [N_DIGITS-1:0]      r_valid, r_blank, r_err, r_seen;
   logic                     r_frame, r_conflict;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_seg_s1 <= SEG_IDLE;
         r_seg_s2 <= SEG_IDLE;
         r_an_s1  <= AN_IDLE;
         r_an_s2  <= AN_IDLE;
      end else begin
         r_seg_s1 <= seg_i;
         r_seg_s2 <= r_seg_s1;
         r_an_s1  <= an_i;
         r_an_s2  <= r_an_s1;
      end
   end

   assign w_seg  = SEG_ACTIVE_LOW ? ~r_seg_s2 : r_seg_s2;
   assign w_an   = AN_ACTIVE_LOW ? ~r_an_s2 : r_an_s2;
   assign w_samp = {w_an, w_seg};

   // r_cnt = (times the current value has been seen) - 1, saturating at STABLE_CYCLES-1.
   // Commit happens on the sample that makes the count reach STABLE_CYCLES; saturation
   // then blocks any re-commit until the value changes.
   assign w_same   = (w_samp == r_prev);
   assign w_commit = w_same && (r_cnt == CW'(STABLE_CYCLES - 2));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev <= '0;
         r_cnt  <= '0;
      end else begin
         r_prev <= w_samp;
         if (!w_same) begin
            r_cnt <= '0;
         end else if (r_cnt != CW'(STABLE_CYCLES - 1)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign w_onehot = $onehot(w_an);
   assign w_multi  = (w_an != '0) && !w_onehot;

   seg7_pat2hex u_pat2hex (
      .i_pat    (w_seg),
      .o_legal  (w_legal),
      .o_blank  (w_blank),
      .o_nibble (w_nibble)
   );

   assign w_all_seen = &r_seen;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_digits   <= '0;
         r_valid    <= '0;
         r_blank    <= '0;
         r_err      <= '0;
         r_seen     <= '0;
         r_frame    <= 1'b0;
         r_conflict <= 1'b0;
      end else begin
         r_frame    <= w_all_seen;
         r_conflict <= w_commit && w_multi;
         // Seen bits clear on the frame pulse, but a commit on that same edge belongs to the next frame.
         r_seen <= (w_all_seen ? '0 : r_seen) | ((w_commit && w_onehot) ? w_an : '0);
         if (w_commit && w_onehot) begin
            for (int i = 0; i < N_DIGITS; i++) begin
               if (w_an[i]) begin
                  r_valid[i] <= w_legal;
                  r_blank[i] <= w_blank;
                  r_err[i]   <= !w_legal && !w_blank;
                  if (w_legal) begin
                     r_digits[i] <= w_nibble;
                  end
               end
            end
         end
      end
   end

   assign digits_o   = r_digits;
   assign valid_o    = r_valid;
   assign blank_o    = r_blank;
   assign err_o      = r_err;
   assign frame_o    = r_frame;
   assign conflict_o = r_conflict;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: a pin-history reference model is compared against the DUT after
// every clock edge, and directed scenarios add literal expectations at fixed points.
module tb_seg7_scan_capture;

   localparam int N = 4;
   localparam int S = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  seg_i = 7'h7F;
   logic [3:0]  an_i = 4'hF;
   logic [15:0] digits_o;
   logic [3:0]  valid_o, blank_o, err_o;
   logic        frame_o, conflict_o;

   seg7_scan_capture #(
      .N_DIGITS(N), .STABLE_CYCLES(S), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .seg_i(seg_i), .an_i(an_i),
      .digits_o(digits_o), .valid_o(valid_o), .blank_o(blank_o), .err_o(err_o),
      .frame_o(frame_o), .conflict_o(conflict_o)
   );

   always #10 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int frame_cnt = 0;
   int conflict_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [10:0] p1, p2, last, s;
   int          run;
   logic [15:0] m_digits;
   logic [3:0]  m_valid, m_blank, m_err, m_seen;
   logic        m_frame, m_conf;
   bit          m_live = 1'b0;

   always @(posedge clk) begin
      logic [3:0] a;
      logic [6:0] sg;
      int         idx, hit;
      if (rst) begin
         p1 = {4'hF, 7'h7F};
         p2 = p1;
         last = '0;
         run = 1;
         m_digits = '0; m_valid = '0; m_blank = '0; m_err = '0; m_seen = '0;
         m_frame = 1'b0; m_conf = 1'b0;
         m_live = 1'b1;
      end else begin
         // Pins reach the logic two edges after they are sampled; active-low -> invert.
         s  = p2 ^ 11'h7FF;
         p2 = p1;
         p1 = {an_i, seg_i};
         if (s == last) begin
            if (run < 1000) run++;
         end else begin
            run = 1;
         end
         last = s;
         m_frame = &m_seen;
         if (m_frame) m_seen = '0;
         m_conf = 1'b0;
         if (run == S) begin
            a  = s[10:7];
            sg = s[6:0];
            if ($countones(a) > 1) begin
               m_conf = 1'b1;
            end else if ($countones(a) == 1) begin
               idx = 0;
               for (int i = 0; i < N; i++) if (a[i]) idx = i;
               m_seen[idx] = 1'b1;
               hit = -1;
               for (int h = 0; h < 16; h++) if (hex_tab[h] == sg) hit = h;
               if (hit >= 0) begin
                  m_digits[4*idx +: 4] = 4'(hit);
                  m_valid[idx] = 1'b1; m_blank[idx] = 1'b0; m_err[idx] = 1'b0;
               end else if (sg == 7'h00) begin
                  m_valid[idx] = 1'b0; m_blank[idx] = 1'b1; m_err[idx] = 1'b0;
               end else begin
                  m_valid[idx] = 1'b0; m_blank[idx] = 1'b0; m_err[idx] = 1'b1;
               end
            end
         end
      end
      if (m_live) begin
         #2;
         check("cyc_digits", 32'(digits_o), 32'(m_digits));
         check("cyc_flags", 32'({valid_o, blank_o, err_o}), 32'({m_valid, m_blank, m_err}));
         check("cyc_pulses", 32'({frame_o, conflict_o}), 32'({m_frame, m_conf}));
         if (frame_o === 1'b1) frame_cnt++;
         if (conflict_o === 1'b1) conflict_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic hold(input logic [3:0] an, input logic [6:0] sg, input int n);
      an_i  = an;
      seg_i = sg;
      repeat (n) @(negedge clk);
   endtask

   logic [6:0] scan_pat [4] = '{7'h4F, 7'h77, 7'h5E, 7'h71};
   logic [3:0] an_sel;

   initial begin
      // 1: reset and idle
      repeat (3) @(negedge clk);
      rst = 1'b0;
      frame_cnt = 0; conflict_cnt = 0;
      hold(4'hF, 7'h7F, 20);
      check("idle_digits", 32'(digits_o), 32'h0);
      check("idle_flags", 32'({valid_o, blank_o, err_o}), 32'h0);
      check("idle_frame_cnt", 32'(frame_cnt), 32'd0);
      check("idle_conflict_cnt", 32'(conflict_cnt), 32'd0);

      // 2: latency of a single dwell on digit 0
      an_i = 4'hE; seg_i = ~7'h06;
      repeat (5) @(posedge clk);
      #3;
      check("lat_edge5_valid", 32'(valid_o), 32'h0);
      check("lat_edge5_digit", 32'(digits_o[3:0]), 32'h0);
      @(posedge clk);
      #3;
      check("lat_edge6_valid", 32'(valid_o), 32'h1);
      check("lat_edge6_digit", 32'(digits_o[3:0]), 32'h1);
      @(negedge clk);
      hold(4'hE, ~7'h06, 2);
      hold(4'hF, 7'h7F, 3);

      // 3: full scan 3,A,d,F
      frame_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         an_sel = ~(4'b0001 << i);
         hold(an_sel, ~scan_pat[i], 8);
         hold(4'hF, 7'h7F, 2);
      end
      hold(4'hF, 7'h7F, 2);
      check("scan_digits", 32'(digits_o), 32'hFDA3);
      check("scan_valid", 32'(valid_o), 32'hF);
      check("scan_frame_cnt", 32'(frame_cnt), 32'd1);

      // 4: blank then illegal pattern on digit 1
      hold(4'hD, 7'h7F, 8);
      check("blank_b1", 32'(blank_o[1]), 32'h1);
      check("blank_v1", 32'(valid_o[1]), 32'h0);
      check("blank_nib", 32'(digits_o[7:4]), 32'hA);
      hold(4'hD, ~7'h49, 8);
      check("err_e1", 32'(err_o[1]), 32'h1);
      check("err_b1", 32'(blank_o[1]), 32'h0);
      check("err_valid", 32'(valid_o), 32'hD);
      check("err_nib", 32'(digits_o[7:4]), 32'hA);
      hold(4'hF, 7'h7F, 2);

      // 5: two anodes at once
      conflict_cnt = 0;
      hold(4'hC, ~7'h3F, 8);
      hold(4'hF, 7'h7F, 2);
      check("conf_cnt", 32'(conflict_cnt), 32'd1);
      check("conf_digits", 32'(digits_o), 32'hFDA3);
      check("conf_valid", 32'(valid_o), 32'hD);

      // 6: short glitch dwell, then reset in mid-dwell and recovery
      hold(4'hE, ~7'h7F, 3);
      hold(4'hF, 7'h7F, 6);
      check("glitch_digits", 32'(digits_o), 32'hFDA3);
      check("glitch_valid", 32'(valid_o), 32'hD);
      hold(4'hE, ~7'h06, 3);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_digits", 32'(digits_o), 32'h0);
      check("rst_flags", 32'({valid_o, blank_o, err_o}), 32'h0);
      rst = 1'b0;
      hold(4'hE, ~7'h06, 10);
      check("recover_digits", 32'(digits_o), 32'h0001);
      check("recover_valid", 32'(valid_o), 32'h1);
      hold(4'hF, 7'h7F, 3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
